// File: rtl/ge_row_array.sv
// One row of the GF(2) Gaussian-elimination systolic array: COLS cells fed through
// an internal skew, with op/pivot tokens linked cell to cell and a deskewed output word.
module ge_row_array #(
   parameter int unsigned COLS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic            start_in,
   input  logic            mode,
   input  logic [COLS-1:0] data_in,
   output logic            valid_out,
   output logic            start_out,
   output logic [COLS-1:0] data_out,
   output logic            pivot_out,
   output logic [COLS-1:0] r_out,
   output logic            idle
);

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_SWAP = 2'b01,
      OP_ADD  = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   // per-beat control pipeline; stage j is the beat currently at cell j
   logic [COLS-1:1] vld_q, vld_d;
   logic [COLS-1:1] st_q, st_d;
   logic [COLS-1:1] md_q, md_d;
   logic [COLS-1:1] piv_q, piv_d;
   op_e             op_q [COLS-1:1];
   op_e             op_d [COLS-1:1];
   logic [COLS-1:0] r_q, r_d;
   logic            valid_out_q, valid_out_d;
   logic            start_out_q, start_out_d;
   logic            pivot_out_q, pivot_out_d;

   logic [COLS-1:0] c_vld, c_st, c_md, c_d, c_piv_in, c_dout, c_piv_out;
   op_e             c_op_in  [COLS];
   op_e             c_op_out [COLS];

   always_comb begin
      c_vld[0]    = valid_in;
      c_st[0]     = start_in;
      c_md[0]     = mode;
      c_piv_in[0] = 1'b0;
      c_op_in[0]  = OP_PASS;
      for (int unsigned j = 1; j < COLS; j++) begin
         c_vld[j]    = vld_q[j];
         c_st[j]     = st_q[j];
         c_md[j]     = md_q[j];
         c_piv_in[j] = piv_q[j];
         c_op_in[j]  = op_q[j];
      end
   end

   always_comb begin
      for (int unsigned j = 0; j < COLS; j++) begin
         r_d[j]       = r_q[j];
         c_dout[j]    = 1'b0;
         c_op_out[j]  = OP_NOP;
         c_piv_out[j] = 1'b0;
         if (c_vld[j]) begin
            if (!c_md[j]) begin
               if (c_st[j]) begin
                  r_d[j]       = c_d[j];
                  c_op_out[j]  = OP_SWAP;
                  c_piv_out[j] = c_piv_in[j] | c_d[j];
               end else if (!c_piv_in[j] && r_q[j]) begin
                  if (c_d[j]) c_op_out[j] = OP_ADD;
                  else        c_op_out[j] = OP_PASS;
                  c_piv_out[j] = 1'b1;
               end else if (!c_piv_in[j]) begin
                  r_d[j]       = c_d[j];
                  c_op_out[j]  = OP_SWAP;
                  c_piv_out[j] = c_d[j];
               end else begin
                  c_op_out[j]  = c_op_in[j];
                  c_piv_out[j] = c_piv_in[j];
                  case (c_op_in[j])
                     OP_SWAP: begin
                        c_dout[j] = r_q[j];
                        r_d[j]    = c_d[j];
                     end
                     OP_ADD:  c_dout[j] = c_d[j] ^ r_q[j];
                     default: c_dout[j] = c_d[j];
                  endcase
               end
            end else begin
               if (c_st[j]) begin
                  c_dout[j]    = r_q[j];
                  c_op_out[j]  = OP_SWAP;
                  c_piv_out[j] = c_piv_in[j] | r_q[j];
               end else if (!c_piv_in[j] && r_q[j]) begin
                  if (c_d[j]) c_op_out[j] = OP_ADD;
                  else        c_op_out[j] = OP_PASS;
                  c_piv_out[j] = 1'b1;
               end else if (!c_piv_in[j]) begin
                  c_dout[j]    = c_d[j];
                  c_op_out[j]  = OP_PASS;
               end else begin
                  c_op_out[j]  = c_op_in[j];
                  c_piv_out[j] = c_piv_in[j];
                  if (c_op_in[j] == OP_ADD) c_dout[j] = c_d[j] ^ r_q[j];
                  else                      c_dout[j] = c_d[j];
               end
            end
         end
      end
   end

   always_comb begin
      for (int unsigned j = 1; j < COLS; j++) begin
         vld_d[j] = c_vld[j-1];
         st_d[j]  = c_st[j-1];
         md_d[j]  = c_md[j-1];
         piv_d[j] = c_piv_out[j-1];
         op_d[j]  = c_op_out[j-1];
      end
      valid_out_d = c_vld[COLS-1];
      start_out_d = c_vld[COLS-1] & c_st[COLS-1];
      pivot_out_d = c_piv_out[COLS-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         st_q        <= '0;
         md_q        <= '0;
         piv_q       <= '0;
         r_q         <= '0;
         valid_out_q <= 1'b0;
         start_out_q <= 1'b0;
         pivot_out_q <= 1'b0;
         for (int unsigned j = 1; j < COLS; j++) op_q[j] <= OP_PASS;
      end else begin
         vld_q       <= vld_d;
         st_q        <= st_d;
         md_q        <= md_d;
         piv_q       <= piv_d;
         r_q         <= r_d;
         valid_out_q <= valid_out_d;
         start_out_q <= start_out_d;
         pivot_out_q <= pivot_out_d;
         for (int unsigned j = 1; j < COLS; j++) op_q[j] <= op_d[j];
      end
   end

   // column j: j-stage input skew, then COLS-j stage deskew ending in the output register
   for (genvar J = 0; J < COLS; J++) begin : g_col
      if (J == 0) begin : g_in
         assign c_d[0] = data_in[0];
      end else begin : g_skew
         logic [J-1:0] sk_q, sk_d;
         always_comb begin
            sk_d[0] = data_in[J];
            for (int unsigned k = 1; k < J; k++) sk_d[k] = sk_q[k-1];
         end
         always_ff @(posedge clk) begin
            if (rst) sk_q <= '0;
            else     sk_q <= sk_d;
         end
         assign c_d[J] = sk_q[J-1];
      end

      logic [COLS-J-1:0] dk_q, dk_d;
      always_comb begin
         dk_d[0] = c_dout[J];
         for (int unsigned k = 1; k < COLS - J; k++) dk_d[k] = dk_q[k-1];
      end
      always_ff @(posedge clk) begin
         if (rst) dk_q <= '0;
         else     dk_q <= dk_d;
      end
      assign data_out[J] = dk_q[COLS-J-1];
   end

   assign valid_out = valid_out_q;
   assign start_out = start_out_q;
   assign pivot_out = pivot_out_q;
   assign r_out     = r_q;
   assign idle      = ~((valid_in & ~rst) | (|vld_q));

endmodule

// File: tb/tb_ge_row_array.sv
// Randomised bench for ge_row_array (COLS=4) against a beat-level elimination model.
module tb_ge_row_array;

   localparam int unsigned COLS  = 4;
   localparam int          NSTEP = 2000;

   logic            clk = 1'b0;
   logic            rst, valid_in, start_in, mode;
   logic [COLS-1:0] data_in;
   logic            valid_out, start_out, pivot_out, idle;
   logic [COLS-1:0] data_out, r_out;

   ge_row_array #(.COLS(COLS)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .start_in(start_in), .mode(mode),
      .data_in(data_in), .valid_out(valid_out), .start_out(start_out),
      .data_out(data_out), .pivot_out(pivot_out), .r_out(r_out), .idle(idle)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n     = 0;
   int last_rst = -1;

   logic [COLS-1:0] mr;
   logic            res_v [NSTEP];
   logic            res_s [NSTEP];
   logic            res_p [NSTEP];
   logic [COLS-1:0] res_d [NSTEP];
   logic [COLS-1:0] rhist [NSTEP];
   logic            iv    [NSTEP];
   logic            cap_v [NSTEP];
   logic            cap_p [NSTEP];
   logic [COLS-1:0] cap_d [NSTEP];
   logic [COLS-1:0] cap_r [NSTEP];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%0h exp=%0h", tag, n, got, exp);
      end
   endtask

   // Whole-beat effect: locate the pivot column, then eliminate or swap the rest.
   task automatic model_beat(input logic s, input logic m, input logic [COLS-1:0] d,
                             output logic [COLS-1:0] q, output logic p);
      logic [COLS-1:0] cand, hi, lo, ones, elim;
      int pv;
      ones = '1;
      q = '0;
      p = 1'b0;
      if (s) begin
         if (!m) begin
            mr = d;
            p  = |d;
         end else begin
            q = mr;
            p = |mr;
         end
      end else begin
         cand = m ? mr : (mr | d);
         pv = -1;
         for (int j = COLS - 1; j >= 0; j--) if (cand[j]) pv = j;
         if (pv < 0) begin
            q = m ? d : '0;
         end else begin
            p    = 1'b1;
            hi   = ones << (pv + 1);
            lo   = ~(ones << pv);
            elim = d[pv] ? (d ^ mr) : d;
            if (m)             q = (d & lo) | (elim & hi);
            else if (mr[pv])   q = elim & hi;
            else begin
               q  = mr & hi;
               mr = (mr & lo) | (d & ~lo);
            end
         end
      end
   endtask

   task automatic step(input logic r_, input logic v, input logic s, input logic m,
                       input logic [COLS-1:0] d);
      logic [COLS-1:0] q, er;
      logic            p, ei;
      int              idx;
      rst = r_; valid_in = v; start_in = s; mode = m; data_in = d;
      res_v[n] = 1'b0; res_s[n] = 1'b0; res_p[n] = 1'b0; res_d[n] = '0;
      iv[n] = v & ~r_;
      if (!r_ && v) begin
         model_beat(s, m, d, q, p);
         res_v[n] = 1'b1; res_s[n] = s; res_d[n] = q; res_p[n] = p;
      end
      #1;
      ei = 1'b1;
      for (int k = 0; k < COLS; k++) if (n - k >= 0 && iv[n-k]) ei = 1'b0;
      if (n > 0) check("idle", idle, ei);
      if (r_) begin
         mr = '0;
         last_rst = n;
         for (int k = 1; k < COLS; k++) begin
            if (n - k >= 0) begin
               iv[n-k] = 1'b0; res_v[n-k] = 1'b0; res_s[n-k] = 1'b0;
               res_p[n-k] = 1'b0; res_d[n-k] = '0;
            end
         end
      end
      rhist[n] = mr;
      @(posedge clk);
      #1;
      idx = n - (COLS - 1);
      if (idx >= 0) begin
         check("valid_out", valid_out, res_v[idx]);
         check("start_out", start_out, res_s[idx]);
         check("data_out",  data_out,  res_d[idx]);
         check("pivot_out", pivot_out, res_p[idx]);
      end else begin
         check("valid_out", valid_out, 0);
         check("data_out",  data_out,  0);
      end
      for (int j = 0; j < COLS; j++) begin
         idx = n - j;
         if (idx < 0 || idx <= last_rst) er[j] = 1'b0;
         else                            er[j] = rhist[idx][j];
      end
      check("r_out", r_out, er);
      cap_v[n] = valid_out; cap_p[n] = pivot_out; cap_d[n] = data_out; cap_r[n] = r_out;
      n++;
   endtask

   task automatic gap(input int cnt);
      for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   int b;

   initial begin
      for (int i = 0; i < NSTEP; i++) begin
         res_v[i] = 1'b0; res_s[i] = 1'b0; res_p[i] = 1'b0; res_d[i] = '0;
         rhist[i] = '0; iv[i] = 1'b0;
         cap_v[i] = 1'b0; cap_p[i] = 1'b0; cap_d[i] = '0; cap_r[i] = '0;
      end
      mr = '0;
      rst = 1'b1; valid_in = 1'b0; start_in = 1'b0; mode = 1'b0; data_in = '0;

      // reset, including a beat offered under reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'hf);
      b = n;
      gap(5);
      for (int k = 0; k < 5; k++) check("rst_vout", cap_v[b+k], 0);
      check("rst_r", cap_r[b+4], 4'b0000);
      check("rst_idle", idle, 1);

      // load in mode 0
      b = n;
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0110);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
      gap(4);
      check("load_b1_v", cap_v[b+3], 1);
      check("load_b1_d", cap_d[b+3], 4'b0000);
      check("load_b1_p", cap_p[b+3], 1);
      check("load_b1_r", cap_r[b+3], 4'b0110);
      check("load_b2_d", cap_d[b+4], 4'b1100);
      check("load_b2_p", cap_p[b+4], 1);
      check("load_r",    cap_r[b+5], 4'b0110);

      // search and swap
      b = n;
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);
      gap(4);
      check("swap_d", cap_d[b+4], 4'b0000);
      check("swap_p", cap_p[b+4], 1);
      check("swap_r", cap_r[b+5], 4'b0100);

      // bubble between two beats
      b = n;
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      gap(5);
      check("bub_v0", cap_v[b+3], 1);
      check("bub_v1", cap_v[b+4], 0);
      check("bub_v2", cap_v[b+5], 1);
      check("bub_r",  cap_r[b+6], 4'b0100);

      // mode 1 offload of a loaded row
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0110);
      b = n;
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1110);
      gap(5);
      check("off_d0", cap_d[b+3], 4'b0110);
      check("off_p0", cap_p[b+3], 1);
      check("off_d1", cap_d[b+4], 4'b1000);
      check("off_p1", cap_p[b+4], 1);
      check("off_r0", cap_r[b+3], 4'b0110);
      check("off_r1", cap_r[b+6], 4'b0110);

      // reset with beats in flight
      b = n;
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'($urandom));
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'($urandom));
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
      gap(5);
      for (int k = 2; k < 7; k++) check("mid_rst_v", cap_v[b+k], 0);
      check("mid_rst_r", cap_r[b+2], 4'b0000);
      check("mid_rst_idle", idle, 1);

      // random traffic
      while (n < NSTEP - 10) begin
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < 75),
              ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 99) < 30),
              4'($urandom));
      end
      gap(6);
      check("end_idle", idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ge_row_array.md
Name: ge_row_array

Overview:
- One full row of the GF(2) Gaussian-elimination triangular systolic array, generalised to COLS processing cells behind a single registered row interface.
- Row words enter unskewed. The block skews them internally, so cell j sees a beat j cycles after cell 0. Op and pivot tokens are registered between adjacent cells. Results are deskewed and leave as one COLS-bit word.
- Adds bubble handling, a per-beat mode, state readout and an idle flag.

Parameters:
- COLS, 8, number of cells/columns in the row (>=2)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  beat present this cycle
- start_in  input  1  init beat (load/offload); qualified by valid_in
- mode  input  1  0 = triangularization, 1 = systemization/offload; sampled per beat
- data_in  input  COLS  row word; bit j = column j (column 0 pivots first)
- valid_out  output  1  result beat present
- start_out  output  1  start flag of the emerging beat
- data_out  output  COLS  result word, aligned
- pivot_out  output  1  pivot token leaving the last cell for this beat
- r_out  output  COLS  current stored bit of every cell
- idle  output  1  no beat in flight

Behaviour:
- Reset:
  - All cell r bits, skew/deskew registers, op/pivot links and the valid pipeline clear to 0.
  - All outputs are 0 except idle=1.
  - Reset mid-stream discards in-flight beats. No stale valid_out appears after rst deasserts.
- Beat transport:
  - valid, start and mode travel with each beat through the skew, so mode may change between consecutive beats.
  - Cell j processes the beat at cycle t+j.
  - Total latency is COLS cycles: valid_out rises exactly COLS cycles after valid_in. Throughput is one beat per cycle.
- Bubbles: when valid is low at a cell, that cell holds r, forwards op=NOP (2'b11) and pivot=0, and produces no output bit.
- Op encoding: 00 PASS, 01 SWAP, 10 ADD, 11 NOP. Cell 0 sees pivot_in=0 and op_in=PASS.
- Cell rule, mode 0 (inputs d, op_in, piv_in):
  - start: r<=d; dout=0; op_out=SWAP; piv_out=piv_in|d.
  - r=1, piv_in=0 (active pivot): r held; dout=0; op_out=d?ADD:PASS; piv_out=1.
  - r=0, piv_in=0 (search): r<=d; dout=0; op_out=SWAP; piv_out=d.
  - otherwise passive, by op_in:
    - PASS: dout=d.
    - SWAP: dout=r, r<=d.
    - ADD: dout=d^r.
    - NOP: dout=d.
    - In all passive cases op_out=op_in and piv_out=piv_in.
- Cell rule, mode 1 (r never changes):
  - start: dout=r; op_out=SWAP; piv_out=piv_in|r.
  - r=1, piv_in=0: dout=0; op_out=d?ADD:PASS; piv_out=1.
  - r=0, piv_in=0: dout=d; op_out=PASS; piv_out=0.
  - otherwise passive: ADD gives d^r; PASS, SWAP and NOP give d. op_out and piv_out forwarded.
- Output registers:
  - pivot_out is the last cell's piv_out, registered and aligned with data_out.
  - r_out is the registered cell state, updated the cycle after each cell processes.
- idle is 1 iff no valid beat exists anywhere in the skew/deskew pipeline, including the beat arriving this cycle.
- Simultaneous rst and valid_in: rst wins and the beat is dropped.

Test Plan (COLS=4, vectors listed {c0,c1,c2,c3}):
- Reset: pulse rst, then hold idle -> r_out={0,0,0,0}, valid_out=0, idle=1; drive valid_in=1 together with rst -> nothing emerges.
- Load, mode 0:
  - Beat 1: start beat d={0,1,1,0}.
  - Beat 2 (next cycle): d={0,1,0,1}.
  - Beat 1 response, cycle 4: valid_out=1, start_out=1, data_out={0,0,0,0}, pivot_out=1, r_out={0,1,1,0}.
  - Beat 2 response, cycle 5: data_out={0,0,1,1}, pivot_out=1, r unchanged.
- Search/swap, mode 0:
  - Beat 1: start d={0,0,0,0}.
  - Beat 2: d={0,0,1,0}.
  - Response: r_out={0,0,1,0}; beat 2 gives data_out={0,0,0,0}, pivot_out=1.
- Bubbles: beats at cycles 0 and 2 with valid_in=0 at cycle 1 -> valid_out pattern 1,0,1 at cycles 4–6; r unaffected by the bubble; idle=0 until the last beat leaves.
- Mode 1 offload, with r={0,1,1,0} loaded:
  - Start beat -> data_out={0,1,1,0}, pivot_out=1.
  - Next beat d={0,1,1,1} -> data_out={0,0,0,1}.
  - r_out stays constant throughout.
- Reset mid-operation: rst at cycle 2 with 3 beats in flight -> valid_out=0 for all following cycles, r_out={0,0,0,0}, idle=1.
